// File: rtl/bta_pkg.sv
// rtl/bta_pkg.sv - shared state type, default sizes and result-width helper
package bta_pkg;

  typedef enum logic [1:0] {COLLECT, WAIT, HOLD} bta_state_e;

  localparam int BTA_N        = 16;
  localparam int BTA_M        = 16;
  localparam int BTA_TREE_LAT = 4;

  function automatic int bta_sum_width(input int m, input int n);
    return m + $clog2(n);
  endfunction

endpackage

// File: rtl/bta_lat_timer.sv
// rtl/bta_lat_timer.sv - loadable down-counter that flags done at zero
module bta_lat_timer #(
  parameter int LOAD_VAL = 4,
  localparam int W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD_VAL);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/bta_operand_collector.sv
// rtl/bta_operand_collector.sv - packs operands for the CLA tree and catches its result
// Optional short batches (in_last) when BTA_SHORT_BATCH_EN is defined.
module bta_operand_collector
  import bta_pkg::*;
#(
  parameter int N        = BTA_N,
  parameter int M        = BTA_M,
  parameter int TREE_LAT = BTA_TREE_LAT,
  localparam int SW      = bta_sum_width(BTA_M, BTA_N) - BTA_M - $clog2(BTA_N) + M + $clog2(N),
  localparam int CW      = $clog2(N),
  localparam int BW      = M * N / 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_data,
  input  logic          in_last,
  output logic [BW-1:0] tree_a,
  output logic [BW-1:0] tree_b,
  output logic [BW-1:0] tree_c,
  output logic [BW-1:0] tree_d,
  output logic          tree_c0,
  input  logic [SW-1:0] tree_sum,
  input  logic          tree_carry,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [SW-1:0] res_sum,
  output logic          res_carry,
  output logic [CW:0]   res_count
);

  localparam int Q = N / 4;

  bta_state_e    state;
  logic [CW-1:0] op_cnt;
  logic [1:0]    bus_sel;
  int            slice_idx;
  logic          accept;
  logic          last_op;
  logic          timer_done;

  assign in_ready  = (state == COLLECT);
  assign accept    = in_valid && in_ready;
  assign tree_c0   = 1'b0;
  assign bus_sel   = 2'(int'(op_cnt) / Q);
  assign slice_idx = int'(op_cnt) % Q;

`ifdef BTA_SHORT_BATCH_EN
  assign last_op = (op_cnt == CW'(N - 1)) || in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign last_op = (op_cnt == CW'(N - 1));
`endif

  bta_lat_timer #(.LOAD_VAL(TREE_LAT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept && last_op),
    .en    (state == WAIT),
    .done  (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      op_cnt    <= '0;
      tree_a    <= '0;
      tree_b    <= '0;
      tree_c    <= '0;
      tree_d    <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_count <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            case (bus_sel)
              2'd0:    tree_a[slice_idx*M +: M] <= in_data;
              2'd1:    tree_b[slice_idx*M +: M] <= in_data;
              2'd2:    tree_c[slice_idx*M +: M] <= in_data;
              default: tree_d[slice_idx*M +: M] <= in_data;
            endcase
            op_cnt <= op_cnt + CW'(1);
            if (last_op) begin
              res_count <= {1'b0, op_cnt} + (CW+1)'(1);
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          // Timer reaching zero leaves one extra edge of margin after the tree latency.
          if (timer_done) begin
            res_sum   <= tree_sum;
            res_carry <= tree_carry;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            tree_a    <= '0;
            tree_b    <= '0;
            tree_c    <= '0;
            tree_d    <= '0;
            op_cnt    <= '0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bta_operand_collector.sv
// tb/tb_bta_operand_collector.sv - randomized bench with tree stub and operand-queue reference
module tb_bta_operand_collector;

  localparam int TL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [63:0] tree_a, tree_b, tree_c, tree_d;
  logic        tree_c0;
  logic [19:0] tree_sum;
  logic        tree_carry;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [19:0] res_sum;
  logic        res_carry;
  logic [4:0]  res_count;
  logic        carry_inj = 1'b0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bta_operand_collector dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .tree_a(tree_a), .tree_b(tree_b), .tree_c(tree_c), .tree_d(tree_d),
    .tree_c0(tree_c0), .tree_sum(tree_sum), .tree_carry(tree_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_count(res_count)
  );

  // Tree stub: sum of all 16 slices, delayed TL edges; carry_inj stands in for a carry-out.
  logic [20:0] pipe [TL];

  function automatic logic [20:0] slice_total();
    logic [20:0] s = '0;
    for (int i = 0; i < 4; i++) begin
      s += 21'(tree_a[i*16 +: 16]) + 21'(tree_b[i*16 +: 16]);
      s += 21'(tree_c[i*16 +: 16]) + 21'(tree_d[i*16 +: 16]);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= slice_total();
    for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
  end

  assign tree_sum   = pipe[TL-1][19:0];
  assign tree_carry = pipe[TL-1][20] | carry_inj;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_sum"}, 64'(res_sum), 64'd0);
    check({tag, "_res_carry"}, 64'(res_carry), 64'd0);
    check({tag, "_res_count"}, 64'(res_count), 64'd0);
    check({tag, "_buses"}, 64'(|{tree_a, tree_b, tree_c, tree_d}), 64'd0);
    check({tag, "_c0"}, 64'(tree_c0), 64'd0);
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("push_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Entered #1 after the last accept edge; stuff keeps in_valid high through hold and handshake.
  task automatic get_result(input string tag, input logic [19:0] es, input logic ec,
                            input logic [4:0] ecnt, input int hold, input bit stuff);
    int t = 0;
    while (res_valid !== 1'b1 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_latency"}, 64'(t), 64'(TL + 1));
    check({tag, "_sum"}, 64'(res_sum), 64'(es));
    check({tag, "_carry"}, 64'(res_carry), 64'(ec));
    check({tag, "_count"}, 64'(res_count), 64'(ecnt));
    if (stuff) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h7777;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
      check({tag, "_hold_sum"}, 64'(res_sum), 64'(es));
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_post_buses"}, 64'(|{tree_a, tree_b, tree_c, tree_d}), 64'd0);
  endtask

  task automatic run_batch(input string tag, input logic [15:0] ops[$], input int last_idx,
                           input int skip, input int ecnt, input int hold, input bit stuff);
    logic [20:0] s;
    logic [63:0] eb [4];
    s = '0;
    for (int i = 0; i < 4; i++) eb[i] = '0;
    carry_inj = 1'($urandom_range(0, 1));
    foreach (ops[k]) begin
      s += 21'(ops[k]);
      eb[k/4][(k%4)*16 +: 16] = ops[k];
    end
    for (int k = skip; k < ops.size(); k++) push(ops[k], k == last_idx);
    check({tag, "_bus_a"}, tree_a, eb[0]);
    check({tag, "_bus_b"}, tree_b, eb[1]);
    check({tag, "_bus_c"}, tree_c, eb[2]);
    check({tag, "_bus_d"}, tree_d, eb[3]);
    get_result(tag, s[19:0], carry_inj, 5'(ecnt), hold, stuff);
  endtask

  initial begin
    logic [15:0] q[$];

    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("after_reset");

    q = {};
    for (int i = 1; i <= 16; i++) q.push_back(16'(i));
    run_batch("seq1to16", q, -1, 0, 16, 0, 1'b0);

    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'hFFFF);
    run_batch("allones", q, -1, 0, 16, 2, 1'b0);

    // Result held 10 cycles with in_valid asserted; 0x7777 becomes operand 0 of the next batch.
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'($urandom));
    run_batch("hold10", q, -1, 0, 16, 10, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("stuffed_first_accept", 64'(tree_a[15:0]), 64'h7777);
    q = {16'h7777};
    for (int i = 1; i < 16; i++) q.push_back(16'($urandom));
    run_batch("after_hold", q, -1, 1, 16, 1, 1'b0);

    for (int i = 0; i < 7; i++) push(16'($urandom), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_reset_state("midbatch_reset");
    @(negedge clk);
    rst_n = 1'b1;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'd2);
    run_batch("twos", q, -1, 0, 16, 0, 1'b0);

    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'd3);
    run_batch("threes", q, -1, 0, 16, 0, 1'b0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'd5);
    run_batch("fives", q, -1, 0, 16, 0, 1'b0);

    q = {};
    for (int i = 0; i < 5; i++) q.push_back(16'h0100);
`ifdef BTA_SHORT_BATCH_EN
    run_batch("short5", q, 4, 0, 5, 1, 1'b0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(16'($urandom));
    run_batch("last_at_15", q, 15, 0, 16, 0, 1'b0);
`else
    for (int i = 0; i < 11; i++) q.push_back(16'h0000);
    run_batch("ignored_last", q, 4, 0, 16, 1, 1'b0);
`endif

    for (int b = 0; b < 3; b++) begin
      q = {};
      for (int i = 0; i < 16; i++) q.push_back(16'($urandom));
      run_batch($sformatf("random%0d", b), q, -1, 0, 16, $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
